// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry circular buffer of
// {inst, addr, predict-jump} with valid/ready handshakes, decode hold and flush.
module if_id_queue #(
    parameter int                 DEPTH  = 4,
    parameter int                 INST_W = 32,
    parameter int                 ADDR_W = 32,
    parameter logic [INST_W-1:0]  NOP    = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       hold_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [INST_W-1:0]          inst_i,
    input  logic [ADDR_W-1:0]          inst_addr_i,
    input  logic                       predict_jump_enable_i,
    output logic                       out_valid_o,
    output logic [INST_W-1:0]          inst_o,
    output logic [ADDR_W-1:0]          inst_addr_o,
    output logic                       predict_jump_enable_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [INST_W-1:0] r_inst_mem [DEPTH];
    logic [ADDR_W-1:0] r_addr_mem [DEPTH];
    logic              r_pj_mem   [DEPTH];

    logic [PTR_W-1:0]  r_wp;
    logic [PTR_W-1:0]  r_rp;
    logic [CNT_W-1:0]  r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == CNT_W'(0));

    // in_ready only sees occupancy and flush, never a same-cycle pop
    assign in_ready_o  = ~w_full & ~flush_i;
    assign out_valid_o = ~w_empty;
    assign w_push      = in_valid_i & in_ready_o;
    assign w_pop       = out_valid_o & ~hold_i;
    assign count_o     = r_count;

    // Pointer and occupancy registers; reset and flush both empty the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= PTR_W'(0);
            r_rp    <= PTR_W'(0);
            r_count <= CNT_W'(0);
        end else if (flush_i) begin
            r_wp    <= PTR_W'(0);
            r_rp    <= PTR_W'(0);
            r_count <= CNT_W'(0);
        end else begin
            if (w_push) begin
                r_wp <= r_wp + PTR_W'(1);
            end else begin
                r_wp <= r_wp;
            end
            if (w_pop) begin
                r_rp <= r_rp + PTR_W'(1);
            end else begin
                r_rp <= r_rp;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents need no reset because outputs are masked when empty
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_inst_mem[r_wp] <= inst_i;
            r_addr_mem[r_wp] <= inst_addr_i;
            r_pj_mem[r_wp]   <= predict_jump_enable_i;
        end
    end

    // Head presentation, driven only from registered state
    always_comb begin
        inst_o                = NOP;
        inst_addr_o           = {ADDR_W{1'b0}};
        predict_jump_enable_o = 1'b0;
        if (out_valid_o) begin
            inst_o                = r_inst_mem[r_rp];
            inst_addr_o           = r_addr_mem[r_rp];
            predict_jump_enable_o = r_pj_mem[r_rp];
        end else begin
            inst_o                = NOP;
            inst_addr_o           = {ADDR_W{1'b0}};
            predict_jump_enable_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_if_id_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        pj;
    } entry_t;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        hold_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        pj_i;
    logic        out_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        pj_o;
    logic [2:0]  count_o;

    int n_checks;
    int n_err;
    bit chk_en;
    entry_t model_q [$];

    if_id_queue #(.DEPTH(DEPTH), .INST_W(32), .ADDR_W(32), .NOP(NOP)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .flush_i               (flush_i),
        .hold_i                (hold_i),
        .in_valid_i            (in_valid_i),
        .in_ready_o            (in_ready_o),
        .inst_i                (inst_i),
        .inst_addr_i           (inst_addr_i),
        .predict_jump_enable_i (pj_i),
        .out_valid_o           (out_valid_o),
        .inst_o                (inst_o),
        .inst_addr_o           (inst_addr_o),
        .predict_jump_enable_o (pj_o),
        .count_o               (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: FIFO of entries; reset/flush empty it, otherwise pop head and append accepted entry
    always @(posedge clk) begin
        bit m_pop;
        bit m_push;
        entry_t e;
        if (rst || flush_i) begin
            model_q.delete();
        end else begin
            m_pop  = (model_q.size() != 0) && !hold_i;
            m_push = in_valid_i && (model_q.size() != DEPTH);
            e.inst = inst_i;
            e.addr = inst_addr_i;
            e.pj   = pj_i;
            if (m_pop) void'(model_q.pop_front());
            if (m_push) model_q.push_back(e);
        end
    end

    // Compare process: every cycle, outputs against model occupancy and head
    always @(negedge clk) begin
        if (chk_en) begin
            int n;
            n = model_q.size();
            chk("count", 64'(count_o), 64'(n));
            chk("out_valid", 64'(out_valid_o), 64'(n != 0));
            chk("in_ready", 64'(in_ready_o), 64'((n != DEPTH) && !flush_i));
            if (n != 0) begin
                chk("inst", 64'(inst_o), 64'(model_q[0].inst));
                chk("addr", 64'(inst_addr_o), 64'(model_q[0].addr));
                chk("pj", 64'(pj_o), 64'(model_q[0].pj));
            end else begin
                chk("inst_empty", 64'(inst_o), 64'(NOP));
                chk("addr_empty", 64'(inst_addr_o), 64'd0);
                chk("pj_empty", 64'(pj_o), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] inst, input logic [31:0] addr, input logic pj);
        in_valid_i  = v;
        inst_i      = inst;
        inst_addr_i = addr;
        pj_i        = pj;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        chk_en   = 1'b0;
        rst      = 1'b1;
        flush_i  = 1'b0;
        hold_i   = 1'b0;
        set_in(1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;

        // Reset and empty
        @(negedge clk);
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_inst", 64'(inst_o), 64'h13);
        chk("rst_addr", 64'(inst_addr_o), 64'd0);
        chk("rst_ready", 64'(in_ready_o), 64'd1);
        chk("rst_count", 64'(count_o), 64'd0);
        #1;

        // Fill under hold, 5th entry pending, then drain in order
        hold_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 32'h1000 + 32'(k), 32'h100 + 32'(4 * k), 1'b0);
            tick();
        end
        set_in(1'b1, 32'h1004, 32'h110, 1'b0);
        @(negedge clk);
        chk("fill_count", 64'(count_o), 64'd4);
        chk("fill_ready", 64'(in_ready_o), 64'd0);
        tick();
        hold_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("drain_addr", 64'(inst_addr_o), 64'(32'h100 + 32'(4 * i)));
            if (i == 1) chk("drain_ready_at3", 64'(in_ready_o), 64'd1);
            tick();
            if (i == 1) in_valid_i = 1'b0;
        end
        @(negedge clk);
        chk("drain_empty", 64'(out_valid_o), 64'd0);
        #1;

        // Streaming: push and pop every cycle, pointers wrap
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 32'h2000 + 32'(i), 32'h200 + 32'(4 * i), 1'(i % 3 == 0));
            tick();
            @(negedge clk);
            chk("stream_addr", 64'(inst_addr_o), 64'(32'h200 + 32'(4 * i)));
            chk("stream_count", 64'(count_o), 64'd1);
            #1;
        end
        in_valid_i = 1'b0;
        tick();

        // Hold with push: count 2 -> 3 -> 4 -> 4, head stable
        hold_i = 1'b1;
        set_in(1'b1, 32'h3000, 32'h300, 1'b0);
        tick();
        set_in(1'b1, 32'h3001, 32'h304, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h3002 + 32'(i), 32'h308 + 32'(4 * i), 1'b0);
            @(negedge clk);
            chk("hold_head", 64'(inst_addr_o), 64'h300);
            chk("hold_count", 64'(count_o), 64'(2 + i));
            tick();
        end
        @(negedge clk);
        chk("hold_count_final", 64'(count_o), 64'd4);
        chk("hold_ready", 64'(in_ready_o), 64'd0);
        #1;
        in_valid_i = 1'b0;
        hold_i     = 1'b0;
        repeat (4) tick();

        // Flush with push and pop in the same cycle
        hold_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 32'h4000 + 32'(k), 32'h400 + 32'(4 * k), 1'b1);
            tick();
        end
        hold_i  = 1'b0;
        flush_i = 1'b1;
        set_in(1'b1, 32'h4444, 32'h444, 1'b1);
        @(negedge clk);
        chk("flush_ready", 64'(in_ready_o), 64'd0);
        tick();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("flush_count", 64'(count_o), 64'd0);
        chk("flush_valid", 64'(out_valid_o), 64'd0);
        chk("flush_inst", 64'(inst_o), 64'h13);
        #1;
        set_in(1'b1, 32'h5000, 32'h500, 1'b0);
        tick();
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("post_flush_addr", 64'(inst_addr_o), 64'h500);
        chk("post_flush_count", 64'(count_o), 64'd1);
        #1;
        tick();

        // Predict flag carriage
        set_in(1'b1, 32'hDEADBEEF, 32'h600, 1'b1);
        tick();
        set_in(1'b1, 32'h00000033, 32'h604, 1'b0);
        @(negedge clk);
        chk("pj1_inst", 64'(inst_o), 64'hDEADBEEF);
        chk("pj1_flag", 64'(pj_o), 64'd1);
        tick();
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("pj0_inst", 64'(inst_o), 64'h33);
        chk("pj0_flag", 64'(pj_o), 64'd0);
        #1;
        tick();

        // Randomized traffic; fetch keeps data stable while stalled
        for (int i = 0; i < 800; i++) begin
            if (!(in_valid_i && !in_ready_o)) begin
                set_in(1'($urandom_range(0, 3) != 0), $urandom(), $urandom(), 1'($urandom_range(0, 1)));
            end
            hold_i  = 1'($urandom_range(0, 2) == 0);
            flush_i = 1'($urandom_range(0, 31) == 0);
            rst     = 1'($urandom_range(0, 127) == 0);
            tick();
        end
        rst = 1'b0;
        flush_i = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
